serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial unsigned subtractor: out = A - B - bi, LSB first, one bit per clk.
//   Counterpart to the combinational ripple adder in the ALU datapath.
//   Trades WIDTH cycles of latency for a single full-subtractor cell.
//   Driven by a start/done handshake from the sequencer.
// PARAMETERS
//   WIDTH  4  operand/result width in bits (>=1)
// PORTS
//   clk    in   1      single clock, rising edge
//   rst_n  in   1      reset, asynchronous, active-low
//   start  in   1      request; sampled on clk rising edge when not busy
//   A      in   WIDTH  minuend, latched when start is accepted
//   B      in   WIDTH  subtrahend, latched when start is accepted
//   bi     in   1      borrow in, latched when start is accepted
//   out    out  WIDTH  difference, valid from done until the next accepted start
//   bo     out  1      borrow out, 1 iff A < B + bi (unsigned)
//   busy   out  1      high while a subtraction is in progress
//   done   out  1      one-cycle pulse: out/bo valid
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE, out=0, bo=0, busy=0, done=0,
//     internal shift regs and counter=0. All outputs are registered.
//   - States:
//     - IDLE: start=1 -> SHIFT. Latch A, B, bi; cnt=0; busy=1.
//     - SHIFT: each edge computes d=a0^b0^br and br'=(~a0&b0)|(~(a0^b0)&br).
//       Shift d into the result MSB end; shift A/B regs right; cnt++.
//       When cnt reaches WIDTH-1 at an edge -> DONE. On that edge out<=result,
//       bo<=br', done=1, busy=0.
//     - DONE: lasts one cycle. start=1 -> SHIFT (back-to-back accepted, same
//       latch as from IDLE). Otherwise -> IDLE. done=0 on leaving.
//   - Latency: start accepted at edge k -> done high after edge k+WIDTH for
//     exactly one cycle. busy is high from edge k until edge k+WIDTH.
//   - Back-to-back throughput: one result every WIDTH+1 cycles.
//   - start while busy (SHIFT) is ignored; the operands are not re-latched.
//   - A, B, bi may change freely after acceptance; the result uses latched values.
//   - out/bo hold their last value through IDLE and through the next SHIFT.
//     They update only at the DONE edge.
//   - Arithmetic: {~bo,out} == A + ~B + ~bi (WIDTH+1 bits).
//     Equivalently out = (A-B-bi) mod 2^WIDTH.
//   - Wrap-around: 0-0 with bi=1 -> out=2^WIDTH-1, bo=1.
//   - Reset mid-operation: aborts immediately. No done pulse. Returns to IDLE
//     with out=0, bo=0.
//   - Counter width $clog2(WIDTH+1). WIDTH=1 works (DONE after one SHIFT edge).
// TESTING (WIDTH=4)
//   1. A=7 B=3 bi=0, start 1 cycle -> busy 4 cycles, done pulse, out=4 bo=0.
//   2. A=3 B=7 bi=0 -> out=12 bo=1; A=0 B=0 bi=1 -> out=15 bo=1 (wrap).
//   3. A=15 B=15 bi=0 -> out=0 bo=0. Then start held high in DONE:
//      second op (A=9 B=2 bi=1 -> out=6 bo=0) begins with no IDLE cycle.
//   4. Pulse start with A=1 B=1 mid-SHIFT of op A=8 B=5 -> ignored;
//      result out=3 bo=0, exactly one done.
//   5. Assert rst_n=0 during cycle 2 of SHIFT -> busy=0, done never pulses,
//      out=0 bo=0. A new start after release works normally.
//   6. 16 random {A,B,bi} ops vs the reference {bo,out} model.
//      Count correct, print mismatches, $fatal if correct!=16.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the bit-serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bi;
  logic [WIDTH-1:0] out;
  logic             bo;
  logic             busy;
  logic             done;

  modport master (output start, A, B, bi, input out, bo, busy, done);
  modport slave  (input start, A, B, bi, output out, bo, busy, done);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: out = A - B - bi, LSB first, one full-subtractor
// cell evaluated per clock; results are published with a one-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, out_q, out_d;
  logic             br_q, br_d, bo_q, bo_d, busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             diff_bit, br_nxt, load;
  logic [WIDTH:0]   res_cat;
  logic [WIDTH-1:0] res_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      out_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      out_q   <= out_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    out_d    = out_q;
    br_d     = br_q;
    bo_d     = bo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    load     = 1'b0;

    diff_bit = a_q[0] ^ b_q[0] ^ br_q;
    br_nxt   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    // Concatenate then drop the LSB so the slice stays legal when WIDTH == 1.
    res_cat  = {diff_bit, res_q};
    res_nxt  = res_cat[WIDTH:1];

    case (state_q)
      IDLE: if (bus.start) load = 1'b1;
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nxt;
        res_d = res_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          out_d   = res_nxt;
          bo_d    = br_nxt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      DONE: begin
        if (bus.start) load = 1'b1;
        else           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance is identical from IDLE and DONE, enabling back-to-back ops.
    if (load) begin
      state_d = SHIFT;
      a_d     = bus.A;
      b_d     = bus.B;
      br_d    = bus.bi;
      res_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end
  end

  assign bus.out  = out_q;
  assign bus.bo   = bo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against an arithmetic reference.
module tb_serial_subtractor;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   rand_ok = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, borrow is the sign of the result.
  function automatic logic [W:0] ref_sub(input int a, input int b, input int bi);
    int d;
    d = a - b - bi;
    return {logic'(d < 0), W'(d & ((1 << W) - 1))};
  endfunction

  // Called just after a negedge; start is accepted at the following posedge.
  task automatic kick(input int a, input int b, input int bi);
    bus.A = W'(a); bus.B = W'(b); bus.bi = bi[0]; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A = W'($urandom); bus.B = W'($urandom); bus.bi = 1'($urandom);
  endtask

  task automatic wait_result(input string tag, input int a, input int b, input int bi,
                             output bit ok);
    logic [W:0] exp;
    exp = ref_sub(a, b, bi);
    ok = 1'b1;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) ok = 1'b0;
    end
    @(negedge clk);
    chk({tag, " done"}, 32'(bus.done), 32'd1);
    chk({tag, " busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, " out"}, 32'(bus.out), 32'(exp[W-1:0]));
    chk({tag, " bo"}, 32'(bus.bo), 32'(exp[W]));
    if (bus.done !== 1'b1 || bus.out !== exp[W-1:0] || bus.bo !== exp[W]) ok = 1'b0;
  endtask

  initial begin
    bit ok;
    int dc, a, b, bi;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.bi = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst out", 32'(bus.out), 32'd0);
    chk("rst bo", 32'(bus.bo), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    kick(7, 3, 0);
    wait_result("t1", 7, 3, 0, ok);
    @(negedge clk);
    chk("t1 done_drop", 32'(bus.done), 32'd0);
    chk("t1 hold_out", 32'(bus.out), 32'd4);

    kick(3, 7, 0);
    wait_result("t2a", 3, 7, 0, ok);
    @(negedge clk);
    kick(0, 0, 1);
    wait_result("t2wrap", 0, 0, 1, ok);
    @(negedge clk);

    kick(15, 15, 0);
    wait_result("t3a", 15, 15, 0, ok);
    kick(9, 2, 1);
    wait_result("t3b2b", 9, 2, 1, ok);
    @(negedge clk);

    dc = done_cnt;
    kick(8, 5, 0);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("t4 busy", 32'(bus.busy), 32'd1);
      if (i == 1) begin bus.start = 1'b1; bus.A = 4'd1; bus.B = 4'd1; bus.bi = 1'b0; end
      if (i == 2) bus.start = 1'b0;
    end
    @(negedge clk);
    chk("t4 done", 32'(bus.done), 32'd1);
    chk("t4 out", 32'(bus.out), 32'd3);
    chk("t4 bo", 32'(bus.bo), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("t4 idle", 32'(bus.busy), 32'd0);
    chk("t4 one_done", 32'(done_cnt - dc), 32'd1);

    kick(7, 3, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5 busy", 32'(bus.busy), 32'd0);
    chk("t5 done", 32'(bus.done), 32'd0);
    chk("t5 out", 32'(bus.out), 32'd0);
    chk("t5 bo", 32'(bus.bo), 32'd0);
    dc = done_cnt;
    repeat (W + 2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("t5 no_done", 32'(done_cnt - dc), 32'd0);
    chk("t5 out_hold", 32'(bus.out), 32'd0);
    kick(10, 4, 0);
    wait_result("t5 after", 10, 4, 0, ok);

    for (int n = 0; n < 16; n++) begin
      a  = int'($urandom_range(0, 15));
      b  = int'($urandom_range(0, 15));
      bi = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      kick(a, b, bi);
      wait_result("t6 rand", a, b, bi, ok);
      if (ok) rand_ok++;
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    if (rand_ok != 16) begin
      $display("FAIL random: observed %0d correct expected 16", rand_ok);
      $fatal(1, "random ops incorrect");
    end
    $finish;
  end
endmodule
